// File: rtl/receive_all_if.sv
// rtl/receive_all_if.sv - inter-board pin side and decoded-message side of receive_all
interface receive_all_if;
  logic       Request_in;
  logic [5:0] inter_data_in;
  logic       Ack_out;
  logic       rx_valid;
  logic [3:0] rx_msg_type;
  logic [4:0] rx_block_x;
  logic [2:0] rx_block_y;
  logic [5:0] rx_card;
  logic [2:0] rx_sel_len;
  logic       rx_move_dir;
  logic       interboard_rst_out;
  logic       busy;

  modport master (
    output Request_in, inter_data_in,
    input  Ack_out, rx_valid, rx_msg_type, rx_block_x, rx_block_y, rx_card,
           rx_sel_len, rx_move_dir, interboard_rst_out, busy
  );

  modport slave (
    input  Request_in, inter_data_in,
    output Ack_out, rx_valid, rx_msg_type, rx_block_x, rx_block_y, rx_card,
           rx_sel_len, rx_move_dir, interboard_rst_out, busy
  );
endinterface

// File: rtl/receive_all.sv
// rtl/receive_all.sv - 4-phase Request/Ack receiver assembling six 6-bit transfers into one message
module receive_all #(
  parameter int SETTLE_CYC = 2,
  parameter int RST_DETECT = 16
) (
  input logic       clk,
  input logic       rst,
  receive_all_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, ACK} state_t;

  localparam logic [3:0] LP_SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [7:0] LP_DET_MAX     = 8'(RST_DETECT);
  localparam logic [7:0] LP_DET_LAST    = 8'(RST_DETECT - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_field_idx, w_field_idx_nxt;
  logic [7:0] r_det_cnt;
  logic       r_req_s1, r_req_s;
  logic [5:0] r_data_s1, r_data_s;
  logic       w_capture, w_frame_done, w_det_cond, w_det_fire;

  logic [3:0] r_f_msg_type, r_rx_msg_type;
  logic [4:0] r_f_block_x,  r_rx_block_x;
  logic [2:0] r_f_block_y,  r_rx_block_y;
  logic [5:0] r_f_card,     r_rx_card;
  logic [2:0] r_f_sel_len,  r_rx_sel_len;
  logic       r_f_move_dir, r_rx_move_dir;
  logic       r_rx_valid, r_irst;

  // Two-flop synchronizers: nothing downstream looks at the raw pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_s1  <= 1'b0;
      r_req_s   <= 1'b0;
      r_data_s1 <= '0;
      r_data_s  <= '0;
    end else begin
      r_req_s1  <= bus.Request_in;
      r_req_s   <= r_req_s1;
      r_data_s1 <= bus.inter_data_in;
      r_data_s  <= r_data_s1;
    end
  end

  assign w_det_cond = !r_req_s && (r_data_s == 6'h3F);
  assign w_det_fire = w_det_cond && (r_det_cnt == LP_DET_LAST);

  // Saturating at the limit means a held line yields a single pulse until it lets go.
  always_ff @(posedge clk) begin
    if (rst || !w_det_cond)
      r_det_cnt <= '0;
    else if (r_det_cnt != LP_DET_MAX)
      r_det_cnt <= r_det_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_field_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_field_idx <= w_field_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_field_idx_nxt = r_field_idx;
    w_capture       = 1'b0;
    w_frame_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_req_s) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        if (!r_req_s) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == LP_SETTLE_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = ACK;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ACK: begin
        if (!r_req_s) begin
          w_state_nxt = IDLE;
          if (r_field_idx == 3'd5) begin
            w_field_idx_nxt = '0;
            w_frame_done    = 1'b1;
          end else begin
            w_field_idx_nxt = r_field_idx + 3'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // A peer reset overrides whatever the handshake was doing, including a completing frame.
    if (w_det_fire) begin
      w_state_nxt     = IDLE;
      w_cnt_nxt       = '0;
      w_field_idx_nxt = '0;
      w_capture       = 1'b0;
      w_frame_done    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_f_msg_type <= '0;
      r_f_block_x  <= '0;
      r_f_block_y  <= '0;
      r_f_card     <= '0;
      r_f_sel_len  <= '0;
      r_f_move_dir <= 1'b0;
    end else if (w_capture) begin
      case (r_field_idx)
        3'd0:    r_f_msg_type <= r_data_s[3:0];
        3'd1:    r_f_block_x  <= r_data_s[4:0];
        3'd2:    r_f_block_y  <= r_data_s[2:0];
        3'd3:    r_f_card     <= r_data_s;
        3'd4:    r_f_sel_len  <= r_data_s[2:0];
        default: r_f_move_dir <= r_data_s[0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_valid    <= 1'b0;
      r_irst        <= 1'b0;
      r_rx_msg_type <= '0;
      r_rx_block_x  <= '0;
      r_rx_block_y  <= '0;
      r_rx_card     <= '0;
      r_rx_sel_len  <= '0;
      r_rx_move_dir <= 1'b0;
    end else begin
      r_rx_valid <= w_frame_done;
      r_irst     <= w_det_fire;
      if (w_det_fire) begin
        r_rx_msg_type <= '0;
        r_rx_block_x  <= '0;
        r_rx_block_y  <= '0;
        r_rx_card     <= '0;
        r_rx_sel_len  <= '0;
        r_rx_move_dir <= 1'b0;
      end else if (w_frame_done) begin
        r_rx_msg_type <= r_f_msg_type;
        r_rx_block_x  <= r_f_block_x;
        r_rx_block_y  <= r_f_block_y;
        r_rx_card     <= r_f_card;
        r_rx_sel_len  <= r_f_sel_len;
        r_rx_move_dir <= r_f_move_dir;
      end
    end
  end

  assign bus.Ack_out            = (r_state == ACK);
  assign bus.busy               = (r_field_idx != 3'd0) || (r_state != IDLE);
  assign bus.rx_valid           = r_rx_valid;
  assign bus.interboard_rst_out = r_irst;
  assign bus.rx_msg_type        = r_rx_msg_type;
  assign bus.rx_block_x         = r_rx_block_x;
  assign bus.rx_block_y         = r_rx_block_y;
  assign bus.rx_card            = r_rx_card;
  assign bus.rx_sel_len         = r_rx_sel_len;
  assign bus.rx_move_dir        = r_rx_move_dir;
endmodule

// File: tb/tb_receive_all.sv
// tb/tb_receive_all.sv - scoreboard bench for receive_all
module tb_receive_all;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  receive_all_if bus();
  receive_all #(.SETTLE_CYC(2), .RST_DETECT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [3:0] mt;
    logic [4:0] bx;
    logic [2:0] by;
    logic [5:0] card;
    logic [2:0] sl;
    logic       md;
  } msg_t;

  msg_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_cnt = 0;
  int   ack_exp = 0;
  int   irst_cnt = 0;
  logic ack_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic msg_t mk(input int a, input int b, input int c, input int d, input int e, input int f);
    msg_t m;
    m.mt = 4'(a); m.bx = 5'(b); m.by = 3'(c); m.card = 6'(d); m.sl = 3'(e); m.md = 1'(f);
    return m;
  endfunction

  function automatic msg_t rx_now();
    msg_t m;
    m.mt = bus.rx_msg_type; m.bx = bus.rx_block_x; m.by = bus.rx_block_y;
    m.card = bus.rx_card; m.sl = bus.rx_sel_len; m.md = bus.rx_move_dir;
    return m;
  endfunction

  // Monitor: counts Ack pulses and peer-reset pulses, pops the scoreboard on every rx_valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.Ack_out && !ack_d) ack_cnt++;
      if (bus.interboard_rst_out) irst_cnt++;
      if (bus.rx_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_valid_unexpected: got 0x%0h, expected no valid", 32'(rx_now()));
        end else begin
          check("rx_message", 32'(rx_now()), 32'(exp_q.pop_front()));
          check("ack_low_at_valid", 32'(bus.Ack_out), 32'd0);
        end
      end
    end
    ack_d = bus.Ack_out;
  end

  task automatic send_field(input logic [5:0] d);
    int n;
    @(posedge clk); #1;
    bus.inter_data_in = d;
    @(posedge clk); #1;
    bus.Request_in = 1'b1;
    ack_exp++;
    n = 0;
    while (!bus.Ack_out && n < 50) begin @(posedge clk); #1; n++; end
    check("ack_rise", 32'(bus.Ack_out), 32'd1);
    bus.Request_in = 1'b0;
    n = 0;
    while (bus.Ack_out && n < 50) begin @(posedge clk); #1; n++; end
    check("ack_fall", 32'(bus.Ack_out), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  task automatic send_frame(input logic [5:0] a, b, c, d, e, f);
    send_field(a); send_field(b); send_field(c);
    send_field(d); send_field(e); send_field(f);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ack"}, 32'(bus.Ack_out), 32'd0);
    check({name, "_flags"}, 32'({bus.rx_valid, bus.interboard_rst_out, bus.busy}), 32'd0);
    check({name, "_rx"}, 32'(rx_now()), 32'd0);
  endtask

  int irst_base;

  initial begin
    rst = 1'b1;
    bus.Request_in = 1'b0;
    bus.inter_data_in = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Full frame
    exp_q.push_back(mk(5, 17, 3, 42, 4, 1));
    send_frame(6'd5, 6'd17, 6'd3, 6'd42, 6'd4, 6'd1);
    repeat (3) @(posedge clk); #1;
    check("busy_after_frame", 32'(bus.busy), 32'd0);
    check("ack_pulses_frame1", 32'(ack_cnt), 32'd6);

    // Upper bits beyond each field width are dropped
    exp_q.push_back(mk(4'hA, 5'h05, 3'h6, 6'h15, 3'h1, 0));
    send_frame(6'h3A, 6'h25, 6'h2E, 6'h15, 6'h39, 6'h22);

    // Request glitch shorter than the settle window
    @(posedge clk); #1;
    bus.Request_in = 1'b1;
    @(posedge clk); #1;
    bus.Request_in = 1'b0;
    repeat (6) @(posedge clk); #1;
    check("glitch_no_ack", 32'(ack_cnt), 32'(ack_exp));
    check("glitch_busy", 32'(bus.busy), 32'd0);

    // Latency: Request sampled high at edge 0, dropped before edge 10
    exp_q.push_back(mk(12, 2, 5, 6, 3, 1));
    @(posedge clk); #1;
    bus.inter_data_in = 6'd12;
    @(posedge clk); #1;
    bus.Request_in = 1'b1;
    ack_exp++;
    repeat (4) @(posedge clk); #1;
    check("lat_ack_after_e3", 32'(bus.Ack_out), 32'd0);
    @(posedge clk); #1;
    check("lat_ack_after_e4", 32'(bus.Ack_out), 32'd1);
    repeat (5) @(posedge clk); #1;
    bus.Request_in = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("lat_ack_after_e11", 32'(bus.Ack_out), 32'd1);
    @(posedge clk); #1;
    check("lat_ack_after_e12", 32'(bus.Ack_out), 32'd0);
    repeat (2) @(posedge clk);
    send_field(6'd2); send_field(6'd5); send_field(6'd6); send_field(6'd3); send_field(6'd1);

    // Peer reset after three fields
    send_field(6'd7); send_field(6'd8); send_field(6'd1);
    irst_base = irst_cnt;
    @(posedge clk); #1;
    bus.inter_data_in = 6'h3F;
    repeat (16) @(posedge clk); #1;
    check("peer_rst_not_early", 32'(irst_cnt), 32'(irst_base));
    check("peer_busy_before", 32'(bus.busy), 32'd1);
    repeat (4) @(posedge clk); #1;
    check("peer_rst_pulse", 32'(irst_cnt), 32'(irst_base + 1));
    check_outputs_zero("peer_rst");
    repeat (10) @(posedge clk); #1;
    check("peer_rst_single", 32'(irst_cnt), 32'(irst_base + 1));
    bus.inter_data_in = 6'd0;
    repeat (3) @(posedge clk);
    exp_q.push_back(mk(2, 9, 4, 33, 6, 1));
    send_frame(6'd2, 6'd9, 6'd4, 6'd33, 6'd6, 6'd1);

    // card = 63 with short gaps is data, not a reset
    irst_base = irst_cnt;
    exp_q.push_back(mk(9, 31, 7, 63, 7, 0));
    send_frame(6'd9, 6'd31, 6'd7, 6'h3F, 6'd7, 6'd0);
    check("card63_no_peer_rst", 32'(irst_cnt), 32'(irst_base));

    // Local rst after field 4
    send_field(6'd10); send_field(6'd11); send_field(6'd12); send_field(6'd13);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_outputs_zero("local_rst");
    rst = 1'b0;
    exp_q.push_back(mk(1, 2, 3, 4, 5, 0));
    send_frame(6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd0);

    repeat (5) @(posedge clk); #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("ack_pulse_total", 32'(ack_cnt), 32'(ack_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
